// File: rtl/pixel_sequencer.sv
// Per-pixel shader sequencer: walks a WIDTH x HEIGHT frame, streams the program ROM
// to the ALU for each pixel and hands the ALU result downstream with valid/ready.
module pixel_sequencer #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int PROG_ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   frame_start,
    input  logic [PROG_ADDR_W:0]   prog_len,
    output logic [PROG_ADDR_W-1:0] prog_addr,
    input  logic [45:0]            prog_data,
    output logic [45:0]            instruction,
    output logic [31:0]            x_coord,
    output logic [31:0]            y_coord,
    output logic [31:0]            f_number,
    input  logic [11:0]            alu_value,
    output logic                   pixel_valid,
    input  logic                   pixel_ready,
    output logic [11:0]            pixel_data,
    output logic                   frame_done
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [45:0] NOP = 46'h2000_0000_0000;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [2:0]           state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [31:0]          f_q, f_d;
    logic [PROG_ADDR_W:0] pc_q, pc_d;
    logic [PROG_ADDR_W:0] len_m1_q, len_m1_d;
    logic [PROG_ADDR_W:0] pc_inc;

    assign pc_inc = pc_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        f_d      = f_q;
        pc_d     = pc_q;
        len_m1_d = len_m1_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_FETCH;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_FETCH: begin
                // Program length is latched once per pixel; zero runs a single instruction.
                pc_d     = '0;
                len_m1_d = (prog_len == '0) ? '0 : prog_len - 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (pc_q == len_m1_q) begin
                    state_d = S_EMIT;
                end else begin
                    pc_d = pc_inc;
                end
            end
            S_EMIT: begin
                if (pixel_ready) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            y_d     = y_q + 1'b1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        x_d     = x_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                f_d     = f_q + 32'd1;
                x_d     = '0;
                y_d     = '0;
                state_d = frame_start ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            f_q      <= '0;
            pc_q     <= '0;
            len_m1_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            f_q      <= f_d;
            pc_q     <= pc_d;
            len_m1_q <= len_m1_d;
        end
    end

    // The ROM answers one cycle late, so RUN always looks one address ahead of pc.
    assign prog_addr   = (state_q == S_RUN) ? pc_inc[PROG_ADDR_W-1:0] : '0;
    assign instruction = (state_q == S_RUN) ? prog_data : NOP;

    assign x_coord     = {{(32 - XW){1'b0}}, x_q};
    assign y_coord     = {{(32 - YW){1'b0}}, y_q};
    assign f_number    = f_q;

    assign pixel_valid = (state_q == S_EMIT);
    assign pixel_data  = (state_q == S_EMIT) ? alu_value : 12'd0;
    assign frame_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_pixel_sequencer.sv
// Directed bench for pixel_sequencer on a 4x2 frame with a behavioural ROM and a
// toy ALU (result = last const + x + 16*y).
module tb_pixel_sequencer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 6;
    localparam logic [45:0] NOP = 46'h2000_0000_0000;

    logic          clk;
    logic          reset_n;
    logic          frame_start;
    logic [AW:0]   prog_len;
    logic [AW-1:0] prog_addr;
    logic [45:0]   prog_data;
    logic [45:0]   instruction;
    logic [31:0]   x_coord, y_coord, f_number;
    logic [11:0]   alu_value;
    logic          pixel_valid;
    logic          pixel_ready;
    logic [11:0]   pixel_data;
    logic          frame_done;

    pixel_sequencer #(.WIDTH(W), .HEIGHT(H), .PROG_ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_start(frame_start),
        .prog_len   (prog_len),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .instruction(instruction),
        .x_coord    (x_coord),
        .y_coord    (y_coord),
        .f_number   (f_number),
        .alu_value  (alu_value),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .pixel_data (pixel_data),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM word k: MOV with const k*16+1, dest k%4 except dest 7 at k=2.
    logic [45:0] rom [0:63];
    initial begin
        for (int k = 0; k < 64; k++) begin
            logic [2:0] d;
            d = (k == 2) ? 3'd7 : 3'(k % 4);
            rom[k] = {d, 31'd0, 12'(k * 16 + 1)};
        end
    end

    always @(posedge clk) prog_data <= rom[prog_addr];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            alu_value <= 12'd0;
        else if (instruction[45:43] != 3'd4)
            alu_value <= instruction[11:0] + x_coord[11:0] + {y_coord[7:0], 4'b0000};
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          x;
        int          y;
        logic [11:0] d;
        int          c;
    } acc_t;

    acc_t acc_q[$];
    acc_t mon_a;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (pixel_valid && pixel_ready) begin
                mon_a.x = int'(x_coord);
                mon_a.y = int'(y_coord);
                mon_a.d = pixel_data;
                mon_a.c = cyc;
                acc_q.push_back(mon_a);
            end
            if (pixel_valid || frame_done)
                check("nop_outside_run", instruction, NOP);
            if (frame_done)
                done_cnt++;
        end
    end

    typedef struct {
        logic [AW:0] plen;
        int          x;
        int          y;
        logic [11:0] d;
        int          gap;
    } vec_t;

    vec_t vec [16];

    task automatic check_reset_values(input string tag);
        check({tag, "_x"},     x_coord,     0);
        check({tag, "_y"},     y_coord,     0);
        check({tag, "_f"},     f_number,    0);
        check({tag, "_addr"},  prog_addr,   0);
        check({tag, "_valid"}, pixel_valid, 0);
        check({tag, "_done"},  frame_done,  0);
        check({tag, "_instr"}, instruction, NOP);
    endtask

    task automatic run_frame(input int base, input int mid_pulse);
        int timed_out;
        prog_len = vec[base].plen;
        acc_q.delete();
        done_cnt = 0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int t = 0; t < 300 && done_cnt == 0; t++) begin
            frame_start = (mid_pulse > 0 && t == mid_pulse);
            tick();
        end
        frame_start = 1'b0;
        timed_out = (done_cnt == 0);
        check("frame_timeout", timed_out, 0);
        tick();
        tick();
        check("pixel_count", acc_q.size(), 8);
        check("done_pulses", done_cnt, 1);
        for (int p = 0; p < 8 && p < acc_q.size(); p++) begin
            $display("vec %0d: pixel (%0d,%0d) data %03h cycle %0d",
                     base + p, acc_q[p].x, acc_q[p].y, acc_q[p].d, acc_q[p].c);
            check("pix_x",    acc_q[p].x, vec[base + p].x);
            check("pix_y",    acc_q[p].y, vec[base + p].y);
            check("pix_data", acc_q[p].d, vec[base + p].d);
            if (p > 0)
                check("pix_gap", acc_q[p].c - acc_q[p - 1].c, vec[base + p].gap);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin
            int f, p;
            f = i / 8;
            p = i % 8;
            vec[i].plen = (f == 0) ? 7'd3 : 7'd0;
            vec[i].x    = p % W;
            vec[i].y    = p / W;
            vec[i].d    = 12'(((f == 0) ? 33 : 1) + vec[i].x + 16 * vec[i].y);
            vec[i].gap  = (f == 0) ? 5 : 3;
        end

        reset_n     = 1'b1;
        frame_start = 1'b0;
        prog_len    = 7'd3;
        pixel_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_reset_values("rst");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_reset_values("idle");

        // Frame 1: three-instruction program, 5 cycles per pixel
        run_frame(0, 0);
        check("f_after_frame1", f_number, 1);

        // Frame 2: zero-length program runs one instruction, 3 cycles per pixel
        run_frame(8, 0);
        check("f_after_frame2", f_number, 2);

        // Frame 3: a frame_start mid-frame must not restart the walk
        run_frame(0, 12);
        check("f_after_frame3", f_number, 3);

        // Frame 4 runs to DONE where frame_start chains straight into frame 5
        prog_len    = 7'd3;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = 0;
        while (!frame_done && n < 300) begin
            tick();
            n++;
        end
        check("frame4_done_seen", frame_done, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("chain_f", f_number, 4);
        check("chain_done_low", frame_done, 0);
        n = 0;
        while (!pixel_valid && n < 20) begin
            tick();
            n++;
        end
        check("chain_latency", n, 4);

        // Backpressure on pixel (0,0) of frame 5
        pixel_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", pixel_valid, 1);
            check("bp_x",     x_coord,     0);
            check("bp_y",     y_coord,     0);
            check("bp_data",  pixel_data,  12'd33);
            check("bp_instr", instruction, NOP);
        end
        pixel_ready = 1'b1;
        tick();
        check("bp_release_valid", pixel_valid, 0);
        check("bp_release_x",     x_coord,     1);

        // Reset asserted during RUN of pixel (2,1)
        n = 0;
        while (!(x_coord == 2 && y_coord == 1 && !pixel_valid) && n < 100) begin
            tick();
            n++;
        end
        check("reach_pixel_2_1", x_coord, 2);
        tick();
        check("run_first_instr", instruction, rom[0]);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_rst");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_reset_values("post_rst");

        run_frame(0, 0);
        check("f_after_restart", f_number, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
